// File: rtl/compare_stream_tracker.sv
// compare_stream_tracker: registers a 4-bit magnitude compare of each new
// sample against the previously accepted one.
// It also tracks the running max and min and the current monotonic run.
// Optional macro EVENT_CNT_EN adds saturating up/down/eq event counters.
//
// state  | meaning
// -------+-----------------------------------------------
// EMPTY  | no stored sample; next accepted sample only loads prev/max/min
// PRIMED | prev holds last accepted sample; next sample produces a compare
module compare_stream_tracker #(
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [3:0]       max_val,
  output logic [3:0]       min_val,
  output logic [1:0]       run_dir,
  output logic [RUN_W-1:0] run_len
`ifdef EVENT_CNT_EN
  ,
  output logic [7:0]       up_cnt,
  output logic [7:0]       down_cnt,
  output logic [7:0]       eq_cnt
`endif
);

  typedef enum logic {EMPTY, PRIMED} state_t;

  localparam logic [1:0]       DIR_NONE = 2'b00;
  localparam logic [1:0]       DIR_UP   = 2'b01;
  localparam logic [1:0]       DIR_DOWN = 2'b10;
  localparam logic [1:0]       DIR_FLAT = 2'b11;
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;

  state_t     state;
  logic [3:0] prev;
  logic       cmp_lt;
  logic       cmp_gt;
  logic       cmp_eq;
  logic [1:0] new_dir;

  // Unsigned magnitude compare of the incoming sample (a) against prev (b).
  always_comb begin
    cmp_lt  = in_data < prev;
    cmp_gt  = in_data > prev;
    cmp_eq  = in_data == prev;
    new_dir = cmp_gt ? DIR_UP : (cmp_lt ? DIR_DOWN : DIR_FLAT);
  end

  // Sequencing of sample acceptance, registered flags, extrema and run tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      prev      <= 4'h0;
      out_valid <= 1'b0;
      a_lt_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      max_val   <= 4'h0;
      min_val   <= 4'hF;
      run_dir   <= DIR_NONE;
      run_len   <= '0;
`ifdef EVENT_CNT_EN
      up_cnt    <= 8'h00;
      down_cnt  <= 8'h00;
      eq_cnt    <= 8'h00;
`endif
    end else if (clear) begin
      // Flush wins over a coincident sample, which is dropped.
      state     <= EMPTY;
      prev      <= 4'h0;
      out_valid <= 1'b0;
      a_lt_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      max_val   <= 4'h0;
      min_val   <= 4'hF;
      run_dir   <= DIR_NONE;
      run_len   <= '0;
`ifdef EVENT_CNT_EN
      up_cnt    <= 8'h00;
      down_cnt  <= 8'h00;
      eq_cnt    <= 8'h00;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        prev <= in_data;
        case (state)
          EMPTY: begin
            max_val <= in_data;
            min_val <= in_data;
            state   <= PRIMED;
          end
          PRIMED: begin
            out_valid <= 1'b1;
            a_lt_b    <= cmp_lt;
            a_gt_b    <= cmp_gt;
            a_eq_b    <= cmp_eq;
            if (in_data > max_val) max_val <= in_data;
            if (in_data < min_val) min_val <= in_data;
            if (new_dir == run_dir) begin
              if (run_len != RUN_MAX) run_len <= run_len + RUN_W'(1);
            end else begin
              run_dir <= new_dir;
              run_len <= RUN_W'(1);
            end
`ifdef EVENT_CNT_EN
            if (cmp_gt && up_cnt   != 8'hFF) up_cnt   <= up_cnt + 8'd1;
            if (cmp_lt && down_cnt != 8'hFF) down_cnt <= down_cnt + 8'd1;
            if (cmp_eq && eq_cnt   != 8'hFF) eq_cnt   <= eq_cnt + 8'd1;
`endif
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_compare_stream_tracker.sv
// Bench for compare_stream_tracker: two instances (RUN_W=4 and RUN_W=2)
// share one stimulus stream and are checked against a history-based model.
// The model keeps every accepted sample since the last reset/clear.
// It derives all outputs from that history.
module tb_compare_stream_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;

  logic       o4_ov, o4_lt, o4_gt, o4_eq;
  logic [3:0] o4_max, o4_min;
  logic [1:0] o4_dir;
  logic [3:0] o4_len;
  logic       o2_ov, o2_lt, o2_gt, o2_eq;
  logic [3:0] o2_max, o2_min;
  logic [1:0] o2_dir;
  logic [1:0] o2_len;
`ifdef EVENT_CNT_EN
  logic [7:0] o4_up, o4_dn, o4_eqc;
  logic [7:0] o2_up, o2_dn, o2_eqc;
`endif

  int checks   = 0;
  int failures = 0;
  int hist[$];
  logic m_ov = 1'b0;

  always #5 clk = ~clk;

  compare_stream_tracker #(.RUN_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(o4_ov), .a_lt_b(o4_lt), .a_gt_b(o4_gt), .a_eq_b(o4_eq),
    .max_val(o4_max), .min_val(o4_min), .run_dir(o4_dir), .run_len(o4_len)
`ifdef EVENT_CNT_EN
    , .up_cnt(o4_up), .down_cnt(o4_dn), .eq_cnt(o4_eqc)
`endif
  );

  compare_stream_tracker #(.RUN_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(o2_ov), .a_lt_b(o2_lt), .a_gt_b(o2_gt), .a_eq_b(o2_eq),
    .max_val(o2_max), .min_val(o2_min), .run_dir(o2_dir), .run_len(o2_len)
`ifdef EVENT_CNT_EN
    , .up_cnt(o2_up), .down_cnt(o2_dn), .eq_cnt(o2_eqc)
`endif
  );

  // direction code of the step from sample b to sample a
  function automatic int dir_of(input int a, input int b);
    if (a > b) return 1;
    if (a < b) return 2;
    return 3;
  endfunction

  function automatic int m_max();
    int r = 0;
    foreach (hist[i]) if (hist[i] > r) r = hist[i];
    return r;
  endfunction

  function automatic int m_min();
    int r = 15;
    foreach (hist[i]) if (hist[i] < r) r = hist[i];
    return r;
  endfunction

  function automatic int m_dir();
    int n = hist.size();
    if (n < 2) return 0;
    return dir_of(hist[n-1], hist[n-2]);
  endfunction

  function automatic int m_len(input int sat);
    int n = hist.size();
    int d;
    int cnt = 0;
    if (n < 2) return 0;
    d = dir_of(hist[n-1], hist[n-2]);
    for (int i = n - 1; i >= 1; i--) begin
      if (dir_of(hist[i], hist[i-1]) != d) break;
      cnt++;
    end
    return (cnt > sat) ? sat : cnt;
  endfunction

  function automatic int m_pairs(input int d);
    int cnt = 0;
    for (int i = 1; i < hist.size(); i++)
      if (dir_of(hist[i], hist[i-1]) == d) cnt++;
    return (cnt > 255) ? 255 : cnt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string nm, input int sat,
                            input logic ov, input logic lt, input logic gt, input logic eq,
                            input logic [3:0] mx, input logic [3:0] mn,
                            input logic [1:0] dir, input logic [3:0] len);
    int d = m_dir();
    chk({nm, ".out_valid"}, 32'(ov),  32'(m_ov));
    chk({nm, ".a_lt_b"},    32'(lt),  32'(d == 2));
    chk({nm, ".a_gt_b"},    32'(gt),  32'(d == 1));
    chk({nm, ".a_eq_b"},    32'(eq),  32'(d == 3));
    chk({nm, ".max_val"},   32'(mx),  32'(m_max()));
    chk({nm, ".min_val"},   32'(mn),  32'(m_min()));
    chk({nm, ".run_dir"},   32'(dir), 32'(d));
    chk({nm, ".run_len"},   32'(len), 32'(m_len(sat)));
  endtask

  task automatic check_all();
    check_inst("w4", 15, o4_ov, o4_lt, o4_gt, o4_eq, o4_max, o4_min, o4_dir, o4_len);
    check_inst("w2", 3,  o2_ov, o2_lt, o2_gt, o2_eq, o2_max, o2_min, o2_dir, {2'b00, o2_len});
`ifdef EVENT_CNT_EN
    chk("w4.up_cnt",   32'(o4_up),  32'(m_pairs(1)));
    chk("w4.down_cnt", 32'(o4_dn),  32'(m_pairs(2)));
    chk("w4.eq_cnt",   32'(o4_eqc), 32'(m_pairs(3)));
    chk("w2.up_cnt",   32'(o2_up),  32'(m_pairs(1)));
    chk("w2.down_cnt", 32'(o2_dn),  32'(m_pairs(2)));
    chk("w2.eq_cnt",   32'(o2_eqc), 32'(m_pairs(3)));
`endif
  endtask

  // one clock of stimulus, then model update and full output check
  task automatic step(input logic c, input logic v, input logic [3:0] d);
    clear    = c;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    m_ov = v && !c && (hist.size() >= 1);
    if (c) hist.delete();
    else if (v) hist.push_back(int'(d));
    clear    = 1'b0;
    in_valid = 1'b0;
    check_all();
  endtask

  initial begin
    logic c, v;
    logic [3:0] d;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    #12;
    check_all();
    rst = 1'b0;

    // 5,5: load then flat compare
    step(0, 1, 4'd5);
    step(0, 1, 4'd5);
    step(0, 0, 4'd0);

    // 3,7,9,12 back-to-back after a flush
    step(1, 0, 4'd0);
    step(0, 1, 4'd3);
    step(0, 1, 4'd7);
    step(0, 1, 4'd9);
    step(0, 1, 4'd12);
    step(0, 0, 4'd0);

    // ramp 0..5 then 2: narrow run counter saturates, then direction flips
    step(1, 0, 4'd0);
    for (int i = 0; i <= 5; i++) step(0, 1, 4'(i));
    step(0, 1, 4'd2);

    // full ramp 0..15 saturates the wide counter too
    step(1, 0, 4'd0);
    for (int i = 0; i <= 15; i++) step(0, 1, 4'(i));
    step(0, 1, 4'd15);

    // 8,4 then clear with a coincident sample (dropped), then 6
    step(1, 0, 4'd0);
    step(0, 1, 4'd8);
    step(0, 1, 4'd4);
    step(1, 1, 4'd15);
    step(0, 1, 4'd6);

    // asynchronous reset mid-stream, checked before the next edge
    step(0, 1, 4'd9);
    #2 rst = 1'b1;
    #1;
    hist.delete();
    m_ov = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 4'hF);
    step(0, 1, 4'h0);

    // long flat stream exercises event counter saturation
    step(1, 0, 4'd0);
    for (int i = 0; i < 300; i++) step(0, 1, 4'd7);

    // randomized stream with occasional flushes and idle cycles
    step(1, 0, 4'd0);
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) d = 4'($urandom_range(0, 15));
      else d = 4'($urandom_range(6, 8));
      step(c, v, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
